// File: rtl/topk_sorter.sv
// rtl/topk_sorter.sv - streaming top-K insertion sorter with ordered drain readout
module topk_sorter #(
  parameter int SORTB = 8,
  parameter int METAB = 32,
  parameter int DEPTH = 8,
  parameter bit REV   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic [SORTB-1:0]             data_i,
  input  logic [METAB-1:0]             metadata_i,
  input  logic                         dav_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [SORTB-1:0]             out_data_o,
  output logic [METAB-1:0]             out_metadata_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         done_o,
  output logic                         evict_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [SORTB*DEPTH-1:0]       data_o,
  output logic [METAB*DEPTH-1:0]       metadata_o,
  output logic [DEPTH-1:0]             valid_o
);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {ACCUM, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [SORTB-1:0] key_q  [DEPTH];
  logic [SORTB-1:0] key_d  [DEPTH];
  logic [METAB-1:0] meta_q [DEPTH];
  logic [METAB-1:0] meta_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             evict_q, evict_d;
  logic             full, accept, pop;

  assign full   = valid_q[DEPTH-1];
  assign accept = (state_q == ACCUM) && dav_i;
  assign pop    = (state_q == DRAIN) && out_ready_i;

  // keep[i]: cell i is occupied and at least as good as the candidate, so it stays put
  always_comb begin
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (REV) keep[i] = valid_q[i] && (key_q[i] <= data_i);
      else     keep[i] = valid_q[i] && (key_q[i] >= data_i);
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    meta_d  = meta_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    evict_d = 1'b0;
    if (clear_i) begin
      valid_d = '0;
      count_d = '0;
      state_d = ACCUM;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        evict_d = full;
        if (!(full && keep[DEPTH-1])) begin
          if (!keep[0]) begin
            key_d[0]  = data_i;
            meta_d[0] = metadata_i;
          end
          for (int i = 1; i < DEPTH; i++) begin
            if (!keep[i]) begin
              if (keep[i-1]) begin
                key_d[i]  = data_i;
                meta_d[i] = metadata_i;
              end else begin
                key_d[i]  = key_q[i-1];
                meta_d[i] = meta_q[i-1];
              end
            end
          end
          valid_d = {valid_q[DEPTH-2:0], 1'b1};
          if (!full) count_d = count_q + CW'(1);
        end
      end
      if (flush_i) begin
        if ((count_q != '0) || accept) state_d = DRAIN;
        else                           done_d  = 1'b1;
      end
    end else if (pop) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        key_d[i]  = key_q[i+1];
        meta_d[i] = meta_q[i+1];
      end
      key_d[DEPTH-1]  = '0;
      meta_d[DEPTH-1] = '0;
      valid_d = {1'b0, valid_q[DEPTH-1:1]};
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        state_d = ACCUM;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      valid_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      evict_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        meta_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      done_q  <= done_d;
      evict_q <= evict_d;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= key_d[i];
        meta_q[i] <= meta_d[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cells
    assign data_o[g*SORTB +: SORTB]     = key_q[g];
    assign metadata_o[g*METAB +: METAB] = meta_q[g];
  end

  assign in_ready_o     = (state_q == ACCUM);
  assign out_valid_o    = (state_q == DRAIN);
  assign out_data_o     = key_q[0];
  assign out_metadata_o = meta_q[0];
  assign done_o         = done_q;
  assign evict_o        = evict_q;
  assign count_o        = count_q;
  assign valid_o        = valid_q;
endmodule

// File: tb/tb_topk_sorter.sv
// tb/tb_topk_sorter.sv - scoreboard bench for topk_sorter (K=4, both sort orders)
module tb_topk_sorter;
  logic         clk, rst;
  logic         clear_i, dav_i, flush_i, out_ready_i;
  logic [7:0]   data_i;
  logic [31:0]  metadata_i;
  logic         in_ready_o, out_valid_o, done_o, evict_o;
  logic [7:0]   out_data_o;
  logic [31:0]  out_metadata_o;
  logic [2:0]   count_o;
  logic [31:0]  data_o;
  logic [127:0] metadata_o;
  logic [3:0]   valid_o;

  logic         dav_r;
  logic [7:0]   data_r;
  logic         in_ready_r, out_valid_r, done_r, evict_r;
  logic [7:0]   out_data_r;
  logic [31:0]  out_metadata_r;
  logic [2:0]   count_r;
  logic [31:0]  data_o_r;
  logic [127:0] metadata_o_r;
  logic [3:0]   valid_r;

  topk_sorter #(.SORTB(8), .METAB(32), .DEPTH(4), .REV(1'b0)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .data_i(data_i), .metadata_i(metadata_i),
    .dav_i(dav_i), .in_ready_o(in_ready_o), .flush_i(flush_i), .out_data_o(out_data_o),
    .out_metadata_o(out_metadata_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .done_o(done_o), .evict_o(evict_o), .count_o(count_o), .data_o(data_o),
    .metadata_o(metadata_o), .valid_o(valid_o)
  );

  topk_sorter #(.SORTB(8), .METAB(32), .DEPTH(4), .REV(1'b1)) dut_r (
    .clk(clk), .rst(rst), .clear_i(1'b0), .data_i(data_r), .metadata_i(32'h0),
    .dav_i(dav_r), .in_ready_o(in_ready_r), .flush_i(1'b0), .out_data_o(out_data_r),
    .out_metadata_o(out_metadata_r), .out_valid_o(out_valid_r), .out_ready_i(1'b0),
    .done_o(done_r), .evict_o(evict_r), .count_o(count_r), .data_o(data_o_r),
    .metadata_o(metadata_o_r), .valid_o(valid_r)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  mk[$];
  logic [31:0] mm[$];
  logic [7:0]  sb_k[$];
  logic [31:0] sb_m[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: best-first list with ties after existing equal keys, capped at 4
  task automatic model_ins(input logic [7:0] k, input logic [31:0] m, output bit ev);
    int p = 0;
    foreach (mk[i]) if (mk[i] >= k) p++;
    ev = 1'b0;
    if (mk.size() == 4 && p == 4) begin
      ev = 1'b1;
    end else begin
      mk.insert(p, k);
      mm.insert(p, m);
      if (mk.size() > 4) begin
        void'(mk.pop_back());
        void'(mm.pop_back());
        ev = 1'b1;
      end
    end
  endtask

  task automatic check_cells(input bit ev);
    logic [31:0]  exp_d = '0, mask_d = '0;
    logic [127:0] exp_m = '0, mask_m = '0;
    logic [3:0]   exp_v = '0;
    for (int i = 0; i < mk.size(); i++) begin
      exp_d[i*8 +: 8]   = mk[i];
      mask_d[i*8 +: 8]  = 8'hFF;
      exp_m[i*32 +: 32] = mm[i];
      mask_m[i*32 +: 32] = 32'hFFFF_FFFF;
      exp_v[i] = 1'b1;
    end
    check("cell_keys", data_o & mask_d, exp_d);
    check("cell_meta", metadata_o & mask_m, exp_m);
    check("valid", valid_o, exp_v);
    check("count", count_o, mk.size());
    check("evict", evict_o, ev);
  endtask

  task automatic ins(input logic [7:0] k, input logic [31:0] m);
    bit ev;
    dav_i = 1'b1; data_i = k; metadata_i = m;
    tick();
    dav_i = 1'b0;
    model_ins(k, m, ev);
    check_cells(ev);
  endtask

  task automatic start_flush();
    foreach (mk[i]) begin
      sb_k.push_back(mk[i]);
      sb_m.push_back(mm[i]);
    end
    mk.delete(); mm.delete();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  // noise drives dav_i/flush_i during the drain; both must be ignored there
  task automatic run_drain(input logic [15:0] pat, input bit noise);
    int cyc = 0;
    int dones = 0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    check("flush_no_done", done_o, 1'b0);
    dav_i = noise; data_i = 8'hFF; flush_i = noise;
    while (sb_k.size() > 0 && cyc < 40) begin
      out_ready_i = (cyc < 16) ? pat[cyc] : 1'b1;
      check("drain_valid", out_valid_o, 1'b1);
      check("drain_in_ready", in_ready_o, 1'b0);
      if (stalled) check("stall_hold", out_data_o, held);
      stalled = !out_ready_i;
      held = out_data_o;
      if (out_ready_i) begin
        check("beat_key", out_data_o, sb_k.pop_front());
        check("beat_meta", out_metadata_o, sb_m.pop_front());
      end
      tick();
      if (done_o) dones++;
      cyc++;
    end
    out_ready_i = 1'b0; dav_i = 1'b0; flush_i = 1'b0;
    check("drain_bound", sb_k.size(), 0);
    check("done_pulses", dones, 1);
    check("ready_after", in_ready_o, 1'b1);
    check("valid_after", out_valid_o, 1'b0);
    check("count_after", count_o, 0);
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0; dav_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    data_i = '0; metadata_i = '0; dav_r = 1'b0; data_r = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", valid_o, 4'h0);
    check("rst_count", count_o, 0);
    check("rst_done", done_o, 1'b0);
    check("rst_evict", evict_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    check("rst_meta", metadata_o, 128'h0);
    tick();
    check("rst_in_ready", in_ready_o, 1'b1);

    ins(8'd5, 32'h105); ins(8'd9, 32'h109); ins(8'd1, 32'h101); ins(8'd7, 32'h107);
    check("fill_order", data_o, 32'h01050709);
    ins(8'd6, 32'h106);
    check("evict_shift", data_o, 32'h05060709);
    ins(8'd0, 32'h100);
    check("evict_reject", data_o, 32'h05060709);

    clear_i = 1'b1; tick(); clear_i = 1'b0;
    mk.delete(); mm.delete();
    check("clear_valid", valid_o, 4'h0);
    check("clear_count", count_o, 0);

    ins(8'd5, 32'hAAAA); ins(8'd5, 32'hBBBB); ins(8'd3, 32'hCCCC);
    check("tie_order", metadata_o[63:0], 64'h0000BBBB_0000AAAA);
    start_flush();
    run_drain(16'hFFFD, 1'b1);

    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("empty_flush_done", done_o, 1'b1);
    check("empty_flush_noval", out_valid_o, 1'b0);
    check("empty_flush_ready", in_ready_o, 1'b1);
    tick();
    check("empty_flush_once", done_o, 1'b0);

    begin
      bit ev;
      dav_i = 1'b1; data_i = 8'h42; metadata_i = 32'h4242;
      model_ins(8'h42, 32'h4242, ev);
      start_flush();
      run_drain(16'hFFFF, 1'b0);
    end

    for (int i = 0; i < 10; i++) ins(8'($urandom_range(0, 20)), $urandom);
    start_flush();
    run_drain(16'hB6D9, 1'b1);

    ins(8'd40, 32'h40); ins(8'd80, 32'h80); ins(8'd60, 32'h60);
    start_flush();
    out_ready_i = 1'b1;
    check("abort_beat1", out_data_o, 8'd80);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0; out_ready_i = 1'b0;
    sb_k.delete(); sb_m.delete();
    check("abort_count", count_o, 0);
    check("abort_valid", valid_o, 4'h0);
    check("abort_no_done", done_o, 1'b0);
    check("abort_state", in_ready_o, 1'b1);
    tick();
    check("abort_no_done2", done_o, 1'b0);

    clear_i = 1'b1; dav_i = 1'b1; data_i = 8'd7;
    tick();
    clear_i = 1'b0; dav_i = 1'b0;
    check("clear_dav_evict", evict_o, 1'b0);
    check("clear_dav_count", count_o, 0);

    ins(8'd11, 32'h11);
    dav_i = 1'b1; data_i = 8'd22; metadata_i = 32'h22;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", valid_o, 4'h0);
    check("rst_mid_count", count_o, 0);
    check("rst_mid_data", data_o, 32'h0);
    check("rst_mid_meta", metadata_o, 128'h0);
    check("rst_mid_evict", evict_o, 1'b0);
    check("rst_mid_out_valid", out_valid_o, 1'b0);
    rst = 1'b0; dav_i = 1'b0;
    mk.delete(); mm.delete();
    tick();
    check("rst_mid_ready", in_ready_o, 1'b1);

    dav_r = 1'b1;
    data_r = 8'd5; tick();
    data_r = 8'd9; tick();
    data_r = 8'd1; tick();
    dav_r = 1'b0;
    check("rev_keys", data_o_r[23:0], 24'h090501);
    check("rev_count", count_r, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/topk_sorter.md
TOPK_SORTER -- requirements
Module: topk_sorter

Interface
REQ-001 The parameters SHALL be as follows, one per line.
- SORTB, 8, sort-key width in bits.
- METAB, 32, metadata width in bits.
- DEPTH, 8, number of sorted cells (K); legal range 2..64.
- REV, 0, sort order: 0 keeps the largest keys with cell 0 = largest; 1 keeps the smallest keys with cell 0 = smallest.
REQ-002 The ports SHALL be as follows, one per line.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous empty/abort.
- data_i  in  SORTB  candidate key.
- metadata_i  in  METAB  candidate metadata.
- dav_i  in  1  candidate valid.
- in_ready_o  out  1  candidate accepted when dav_i & in_ready_o.
- flush_i  in  1  start ordered readout.
- out_data_o  out  SORTB  readout key.
- out_metadata_o  out  METAB  readout metadata.
- out_valid_o  out  1  readout valid.
- out_ready_i  in  1  readout consumer ready.
- done_o  out  1  one-cycle pulse, readout finished.
- evict_o  out  1  one-cycle pulse, an entry was discarded.
- count_o  out  clog2(DEPTH+1)  occupied cells.
- data_o  out  SORTB x DEPTH  cell keys.
- metadata_o  out  METAB x DEPTH  cell metadata.
- valid_o  out  DEPTH  cell occupancy.

Function
REQ-003 The block SHALL have two states, ACCUM and DRAIN; in_ready_o = 1 exactly in ACCUM.
REQ-004 Occupied cells SHALL always be contiguous from cell 0 and ordered best-first; count_o SHALL equal popcount(valid_o).
REQ-005 "Better" SHALL mean strictly greater when REV=0 and strictly smaller when REV=1, compared unsigned.
REQ-006 An accepted candidate SHALL be inserted at p = number of occupied cells better-or-equal to it, so ties preserve arrival order.
REQ-007 On insertion, cells p..DEPTH-2 SHALL shift one position toward DEPTH-1; the result SHALL be visible on the cell outputs on the cycle after acceptance.
REQ-008 If the block is full and p < DEPTH, the old cell DEPTH-1 SHALL be dropped and evict_o SHALL pulse.
REQ-009 If the block is full and p = DEPTH, the candidate SHALL be discarded, the array left unchanged, and evict_o SHALL pulse.
REQ-010 In ACCUM, flush_i with count_o > 0 SHALL enter DRAIN on the next cycle; a candidate accepted on the same cycle SHALL be included in the drain.
REQ-011 In ACCUM, flush_i with count_o = 0 and no same-cycle accept SHALL pulse done_o on the next cycle and remain in ACCUM.
REQ-012 In DRAIN, out_valid_o SHALL be 1 and out_data_o/out_metadata_o SHALL equal cell 0.
REQ-013 Each out_valid_o & out_ready_i SHALL shift all cells one position toward cell 0, clear the top occupied cell, and decrement count_o.
REQ-014 The handshake that pops the last entry SHALL return the block to ACCUM and pulse done_o on the next cycle.
REQ-015 Outside DRAIN, out_valid_o SHALL be 0; out_data_o and out_metadata_o SHALL still mirror cell 0.
REQ-016 In DRAIN, dav_i and flush_i SHALL be ignored.
REQ-017 clear_i SHALL have highest priority: all valid_o go to 0, the state goes to ACCUM, and any drain is aborted without a done_o pulse.
REQ-018 A same-cycle candidate SHALL be dropped when clear_i is asserted, with no evict_o.
REQ-019 An out_ready_i held low in DRAIN SHALL hold cell 0 and out_valid_o stable.
REQ-020 The design SHALL contain no combinational path from dav_i or data_i to any output.

Reset
REQ-021 On rst, the block SHALL be in ACCUM.
REQ-022 On rst, valid_o, count_o, done_o, evict_o and out_valid_o SHALL be 0, and all data and metadata registers SHALL be 0.
REQ-023 On rst, in_ready_o SHALL be 1 from the first clock after rst deasserts.
REQ-024 Assertion of rst mid-DRAIN SHALL take effect immediately, with no done_o pulse.

Verification
REQ-025 DEPTH=4, REV=0: insert keys 5,9,1,7 -> data_o = 9,7,5,1, count_o = 4, evict_o never pulses.
REQ-026 Full array 9,7,5,1: insert 6 -> array 9,7,6,5 with one evict_o pulse; then insert 0 -> array unchanged with one evict_o pulse.
REQ-027 Ties: insert key 5 with metadata A, then key 5 with metadata B -> A in the lower cell index; REV=1 with keys 5,9,1 -> 1,5,9.
REQ-028 Three entries, flush_i, out_ready_i toggling 1,0,1,1 -> three beats in best-first order, data held during the stall, one done_o pulse, in_ready_o = 1 afterwards.
REQ-029 flush_i on an empty array -> done_o on the next cycle and no out_valid_o; flush_i with a same-cycle dav_i on an empty array -> one beat, then done_o.
REQ-030 clear_i during the second drain beat -> count_o = 0, no done_o pulse; rst mid-insert -> all outputs at reset values.
